multi_counter_host: RTL
=======================

MULTI_COUNTER_HOST -- requirements
Module: multi_counter_host

Interface
REQ-001 SHALL have parameter CNTRS_N, default 256, number of counters addressed.
REQ-002 SHALL have parameter CNTRS_W, default 32, counter data width.
REQ-003 SHALL have parameter CNTRS_ID_W, default $clog2(CNTRS_N), counter id width.
REQ-004 SHALL have parameter RSP_DEPTH, default 4, response FIFO depth and query credit count; power of 2, at least 2.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: req_vld  in  1  request valid; req_rdy  out  1  request ready.
REQ-007 SHALL have ports: req_id  in  CNTRS_ID_W  counter id; req_op  in  multi_counter_pkg::op_t  operation; req_dat  in  CNTRS_W  operand.
REQ-008 SHALL have ports: cntr_pass  out  1  command valid; cntr_id  out  CNTRS_ID_W  id; cntr_op  out  op_t  op; cntr_dat  out  CNTRS_W  data. All four are registered.
REQ-009 SHALL have ports: status_pass_r  in  1  status valid; status_qry_r  in  1  query result; status_id_r  in  CNTRS_ID_W  id; status_dat_r  in  CNTRS_W  value.
REQ-010 SHALL have ports: rsp_vld  out  1; rsp_rdy  in  1; rsp_id  out  CNTRS_ID_W; rsp_dat  out  CNTRS_W.
REQ-011 SHALL have ports: outstanding  out  $clog2(RSP_DEPTH)+1  count of queries issued but not yet popped; err_r  out  1  sticky protocol error.

Function
REQ-012 A query SHALL be a request whose req_op[multi_counter_pkg::OP_OUTPUT_B] is set.
REQ-013 A credit counter SHALL start at RSP_DEPTH, decrement on query accept, and increment on rsp handshake; accept and pop in the same cycle SHALL leave it unchanged.
REQ-014 req_rdy SHALL equal ~rst & ((credits != 0) | ~req_op[OP_OUTPUT_B]) and SHALL NOT depend on req_vld.
REQ-015 On a req_vld & req_rdy cycle, cntr_pass SHALL be 1 in the next cycle with cntr_id/op/dat equal to the accepted req_id/op/dat.
REQ-016 When no request is accepted, cntr_pass SHALL be 0 next cycle and cntr_id/op/dat SHALL hold their values.
REQ-017 The block SHALL sustain one command per cycle, including back-to-back queries, while credits remain.
REQ-018 A cycle with status_pass_r & status_qry_r SHALL push {status_id_r, status_dat_r} into the response FIFO; all other status cycles SHALL be ignored.
REQ-019 rsp_vld SHALL assert the cycle after a push into an empty FIFO; with a connected multi_counter, the first rsp_vld SHALL therefore occur 6 cycles after query accept.
REQ-020 The FIFO SHALL return entries in push order, wrap pointers modulo RSP_DEPTH, and support simultaneous push and pop when full or empty-with-bypass-free timing (a push into empty does not pop in the same cycle).
REQ-021 rsp_id and rsp_dat SHALL be stable while rsp_vld & ~rsp_rdy.
REQ-022 outstanding SHALL equal RSP_DEPTH - credits.
REQ-023 If a status query arrives while the FIFO is full, or while outstanding == FIFO occupancy (no query in flight), the entry SHALL be dropped and err_r set.
REQ-024 err_r SHALL remain set until reset.

Reset
REQ-025 While rst is high: cntr_pass=0, cntr_id/op/dat=0, rsp_vld=0, rsp_id/dat=0, req_rdy=0, err_r=0, outstanding=0, credits=RSP_DEPTH, FIFOs empty.
REQ-026 A reset asserted mid-operation SHALL discard all in-flight and buffered queries; a status query arriving after reset with none outstanding SHALL set err_r per REQ-023.

Configuration
REQ-027 Macro MULTI_COUNTER_HOST_CHK_EN defined: a RSP_DEPTH-deep tag FIFO SHALL record each issued query id at accept. Each status query SHALL pop it, and an id mismatch SHALL set err_r.
REQ-028 Macro MULTI_COUNTER_HOST_CHK_EN undefined: no tag FIFO SHALL exist, and err_r SHALL be set only by REQ-023 conditions.

Verification
REQ-029 Bench SHALL drive INIT id 5 dat 0x10, INCR id 5, then query id 5 with a connected multi_counter -> rsp_vld with rsp_id=5 and rsp_dat=0x11, arriving 6 cycles after query accept.
REQ-030 Bench SHALL issue 4 queries with rsp_rdy=0 and RSP_DEPTH=4 -> outstanding=4 and req_rdy=0 for queries, while a non-query request is still accepted; asserting rsp_rdy then drains 4 responses in order.
REQ-031 Bench SHALL hold rsp_rdy=0 with rsp_vld=1 for 3 cycles -> rsp_id and rsp_dat unchanged across those cycles.
REQ-032 Bench SHALL inject a status query with outstanding=0 -> entry dropped, err_r=1 next cycle and held until rst.
REQ-033 With MULTI_COUNTER_HOST_CHK_EN, bench SHALL issue a query for id 3 and return a status for id 7 -> err_r=1; without the macro, err_r stays 0 and rsp_id=7.
REQ-034 Bench SHALL assert rst with 2 queries in flight -> all outputs zero next cycle, outstanding=0, credits restored to RSP_DEPTH.

Source files
------------

// File: rtl/multi_counter_host.sv
// multi_counter_host: request front-end and response collector for a multi_counter.
//   Accepts counter commands (req_*) and forwards them one cycle later on cntr_*.
//   A command whose op has the OUTPUT bit set is a query. Queries consume a credit,
//   so no more than RSP_DEPTH results can ever be owed. Query results come back on
//   status_*_r and are buffered in a response FIFO that drains over rsp_*.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_vld/rdy/id/op/dat      command input (req_rdy is combinational)
//   cntr_pass/id/op/dat        registered command to the multi_counter
//   status_pass_r/qry_r/id_r/dat_r  status returned by the multi_counter
//   rsp_vld/rdy/id/dat         query response output
//   outstanding                queries issued but not yet popped
//   err_r                      sticky protocol error
// Optional feature: define MULTI_COUNTER_HOST_CHK_EN to add a tag FIFO. The tag FIFO
// records each query id at accept and compares it against the id of every returned
// status query.

package multi_counter_pkg;

  localparam int unsigned OP_W        = 3;
  localparam int unsigned OP_OUTPUT_B = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP         = 3'd0,
    OP_INIT        = 3'd1,
    OP_INCR        = 3'd2,
    OP_DECR        = 3'd3,
    OP_OUTPUT      = 3'd4,
    OP_INIT_OUTPUT = 3'd5,
    OP_INCR_OUTPUT = 3'd6,
    OP_DECR_OUTPUT = 3'd7
  } op_t;

endpackage

module multi_counter_host
  import multi_counter_pkg::*;
#(
  parameter int unsigned CNTRS_N    = 256,
  parameter int unsigned CNTRS_W    = 32,
  parameter int unsigned CNTRS_ID_W = $clog2(CNTRS_N),
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic [CNTRS_ID_W-1:0]   req_id,
  input  op_t                     req_op,
  input  logic [CNTRS_W-1:0]      req_dat,

  output logic                    cntr_pass,
  output logic [CNTRS_ID_W-1:0]   cntr_id,
  output op_t                     cntr_op,
  output logic [CNTRS_W-1:0]      cntr_dat,

  input  logic                    status_pass_r,
  input  logic                    status_qry_r,
  input  logic [CNTRS_ID_W-1:0]   status_id_r,
  input  logic [CNTRS_W-1:0]      status_dat_r,

  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [CNTRS_ID_W-1:0]   rsp_id,
  output logic [CNTRS_W-1:0]      rsp_dat,

  output logic [$clog2(RSP_DEPTH):0] outstanding,
  output logic                    err_r
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  // Elaboration-time parameter legality.
  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RSP_DEPTH must be a power of 2 and at least 2");
  end
  if (CNTRS_N > (2 ** CNTRS_ID_W)) begin : g_bad_id_w
    $error("CNTRS_ID_W too narrow for CNTRS_N");
  end

  logic [CNT_W-1:0] credits_c;
  logic             req_acc_c;
  logic             qry_acc_c;
  logic             pop_c;
  logic             sts_qry_c;
  logic             full_c;
  logic             in_flight_c;
  logic             drop_c;
  logic             push_c;
  logic             tag_err_c;

  logic [CNTRS_ID_W-1:0] fifo_id  [RSP_DEPTH];
  logic [CNTRS_W-1:0]    fifo_dat [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      rsp_cnt;
  logic [CNT_W-1:0]      rsp_cnt_nxt_c;

  // Credits are the complement of outstanding; only queries are throttled.
  assign credits_c = DEPTH_C - outstanding;
  assign req_rdy   = ~rst & ((credits_c != '0) | ~req_op[OP_OUTPUT_B]);
  assign req_acc_c = req_vld & req_rdy;
  assign qry_acc_c = req_acc_c & req_op[OP_OUTPUT_B];
  assign pop_c     = rsp_vld & rsp_rdy;
  assign sts_qry_c = status_pass_r & status_qry_r;

  // A result is only legal if some query is still between accept and FIFO push.
  assign full_c      = (rsp_cnt == DEPTH_C);
  assign in_flight_c = (outstanding != rsp_cnt);
  assign drop_c      = sts_qry_c & (full_c | ~in_flight_c);
  assign push_c      = sts_qry_c & ~drop_c;

  // Command pipeline register toward the multi_counter; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cntr_pass <= 1'b0;
      cntr_id   <= '0;
      cntr_op   <= OP_NOP;
      cntr_dat  <= '0;
    end else begin
      cntr_pass <= req_acc_c;
      if (req_acc_c) begin
        cntr_id  <= req_id;
        cntr_op  <= req_op;
        cntr_dat <= req_dat;
      end
    end
  end

  // Outstanding query count: up on query accept, down on response pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({qry_acc_c, pop_c})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Response FIFO occupancy next state.
  always_comb begin
    rsp_cnt_nxt_c = rsp_cnt;
    if (push_c & ~pop_c) begin
      rsp_cnt_nxt_c = rsp_cnt + CNT_W'(1);
    end else if (pop_c & ~push_c) begin
      rsp_cnt_nxt_c = rsp_cnt - CNT_W'(1);
    end
  end

  // Response FIFO storage and pointers; pointers wrap naturally at RSP_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rsp_cnt <= '0;
      rsp_vld <= 1'b0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        fifo_id[i]  <= '0;
        fifo_dat[i] <= '0;
      end
    end else begin
      if (push_c) begin
        fifo_id[wr_ptr]  <= status_id_r;
        fifo_dat[wr_ptr] <= status_dat_r;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      rsp_cnt <= rsp_cnt_nxt_c;
      rsp_vld <= (rsp_cnt_nxt_c != '0);
    end
  end

  // Head entry comes straight from storage, so it is stable while not popped.
  assign rsp_id  = fifo_id[rd_ptr];
  assign rsp_dat = fifo_dat[rd_ptr];

`ifdef MULTI_COUNTER_HOST_CHK_EN
  logic [CNTRS_ID_W-1:0] tag_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      tag_wr_ptr;
  logic [PTR_W-1:0]      tag_rd_ptr;
  logic [CNT_W-1:0]      tag_cnt;
  logic                  tag_push_c;
  logic                  tag_pop_c;

  // Tag count never exceeds outstanding, so credit gating also bounds this FIFO.
  assign tag_push_c = qry_acc_c & (tag_cnt != DEPTH_C);
  assign tag_pop_c  = sts_qry_c & (tag_cnt != '0);
  assign tag_err_c  = tag_pop_c & (tag_mem[tag_rd_ptr] != status_id_r);

  // Tag FIFO: issued query ids in accept order.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        tag_mem[i] <= '0;
      end
    end else begin
      if (tag_push_c) begin
        tag_mem[tag_wr_ptr] <= req_id;
        tag_wr_ptr          <= tag_wr_ptr + PTR_W'(1);
      end
      if (tag_pop_c) begin
        tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
      end
      case ({tag_push_c, tag_pop_c})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end
`else
  assign tag_err_c = 1'b0;
`endif

  // Sticky error: cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (drop_c | tag_err_c) begin
      err_r <= 1'b1;
    end
  end

endmodule
